cmatmul_engine: RTL and testbench



---
 rtl/cmatmul_engine_if.sv | 46 ++++
 rtl/cmatmul_engine.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cmatmul_engine.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmatmul_engine_if.sv
// Host-side bus of the complex matrix-multiply engine: A/B operand load
// ports, the start/busy/done run handshake and the C result read port.
interface cmatmul_engine_if #(
  parameter int M  = 3,
  parameter int K  = 3,
  parameter int N  = 3,
  parameter int DW = 32
);
  localparam int A_AW = (M * K > 1) ? $clog2(M * K) : 1;
  localparam int B_AW = (K * N > 1) ? $clog2(K * N) : 1;
  localparam int C_AW = (M * N > 1) ? $clog2(M * N) : 1;

  logic            wr_a_en;
  logic [A_AW-1:0] wr_a_addr;
  logic [DW-1:0]   wr_a_re;
  logic [DW-1:0]   wr_a_im;

  logic            wr_b_en;
  logic [B_AW-1:0] wr_b_addr;
  logic [DW-1:0]   wr_b_re;
  logic [DW-1:0]   wr_b_im;

  logic            conj_b;
  logic            start;
  logic            busy;
  logic            done;
  logic            sat;

  logic [C_AW-1:0] rd_addr;
  logic [DW-1:0]   rd_re;
  logic [DW-1:0]   rd_im;

  modport master (
    output wr_a_en, wr_a_addr, wr_a_re, wr_a_im,
    output wr_b_en, wr_b_addr, wr_b_re, wr_b_im,
    output conj_b, start, rd_addr,
    input  busy, done, sat, rd_re, rd_im
  );

  modport slave (
    input  wr_a_en, wr_a_addr, wr_a_re, wr_a_im,
    input  wr_b_en, wr_b_addr, wr_b_re, wr_b_im,
    input  conj_b, start, rd_addr,
    output busy, done, sat, rd_re, rd_im
  );
endinterface

// File: rtl/cmatmul_engine.sv
// Complex matrix-multiply engine: C = A*B or A*conj(B), A is MxK, B is KxN.
// Operands are Q5.27, results Q16.16. One (i,j,k) term is issued per cycle
// through a five-stage pipeline (issue, RAM read, products, complex sum,
// accumulate/convert); each finished dot product is saturated and written to
// the internal C buffer, which is readable at any time with one cycle latency.
module cmatmul_engine #(
  parameter int M  = 3,
  parameter int K  = 3,
  parameter int N  = 3,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  cmatmul_engine_if.slave  bus
);
  localparam int A_AW  = (M * K > 1) ? $clog2(M * K) : 1;
  localparam int B_AW  = (K * N > 1) ? $clog2(K * N) : 1;
  localparam int C_AW  = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int I_W   = (M > 1) ? $clog2(M) : 1;
  localparam int J_W   = (N > 1) ? $clog2(N) : 1;
  localparam int K_W   = (K > 1) ? $clog2(K) : 1;
  localparam int PW    = 2 * DW;
  localparam int SW    = PW + 1;
  localparam int ACC_W = SW + $clog2(K);
  localparam int SHIFT = 2 * (DW - 5) - 16;

  localparam logic [I_W-1:0] I_LAST  = I_W'(M - 1);
  localparam logic [J_W-1:0] J_LAST  = J_W'(N - 1);
  localparam logic [K_W-1:0] K_LAST  = K_W'(K - 1);
  localparam logic [DW-1:0]  POS_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]  NEG_MAX = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_n;

  logic [DW-1:0] a_re_mem [M*K];
  logic [DW-1:0] a_im_mem [M*K];
  logic [DW-1:0] b_re_mem [K*N];
  logic [DW-1:0] b_im_mem [K*N];
  logic [DW-1:0] c_re_mem [M*N];
  logic [DW-1:0] c_im_mem [M*N];

  logic [I_W-1:0]  i_cnt;
  logic [J_W-1:0]  j_cnt;
  logic [K_W-1:0]  k_cnt;
  logic [A_AW-1:0] a_idx;
  logic [B_AW-1:0] b_idx;
  logic [C_AW-1:0] c_idx;
  logic            conj_q;

  logic run_active;
  logic start_ok;
  logic issue;
  logic last_issue;
  logic pipe_busy;

  logic s0_v, s1_v, s2_v, s3_v;

  logic [A_AW-1:0] s0_a;
  logic [B_AW-1:0] s0_b;
  logic [C_AW-1:0] s0_c, s1_c, s2_c, s3_c;
  logic            s0_first, s1_first, s2_first, s3_first;
  logic            s0_last, s1_last, s2_last, s3_last;

  logic signed [DW-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] s3_re, s3_im;

  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic signed [ACC_W-1:0] acc_re_n, acc_im_n;
  logic [DW:0]             conv_re, conv_im;

  logic          sat_q;
  logic [DW-1:0] rd_re_q, rd_im_q;

  // Shift a Q(.54) accumulator down to Q16.16 (floor) and clamp to the
  // signed DW-bit range; the top bit of the result flags a clamp.
  function automatic logic [DW:0] to_q16(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if ((&s[ACC_W-1:DW-1]) || !(|s[ACC_W-1:DW-1])) begin
      return {1'b0, s[DW-1:0]};
    end else if (s[ACC_W-1]) begin
      return {1'b1, NEG_MAX};
    end else begin
      return {1'b1, POS_MAX};
    end
  endfunction

  assign run_active = (state == RUN) || (state == DRAIN);
  assign start_ok   = (state == IDLE) && bus.start;
  assign issue      = (state == RUN);
  assign last_issue = (i_cnt == I_LAST) && (j_cnt == J_LAST) && (k_cnt == K_LAST);
  assign pipe_busy  = s0_v || s1_v || s2_v || s3_v;

  assign bus.busy  = run_active;
  assign bus.done  = (state == DONE);
  assign bus.sat   = sat_q;
  assign bus.rd_re = rd_re_q;
  assign bus.rd_im = rd_im_q;

  // Run-control state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: issue every term, then wait for the pipeline to empty.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last_issue) state_n = DRAIN;
      DRAIN:   if (!pipe_busy) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand loads, locked out while a run is reading the buffers.
  always_ff @(posedge clk) begin
    if (bus.wr_a_en && !run_active) begin
      a_re_mem[bus.wr_a_addr] <= bus.wr_a_re;
      a_im_mem[bus.wr_a_addr] <= bus.wr_a_im;
    end
    if (bus.wr_b_en && !run_active) begin
      b_re_mem[bus.wr_b_addr] <= bus.wr_b_re;
      b_im_mem[bus.wr_b_addr] <= bus.wr_b_im;
    end
  end

  // Loop counters (i outer, j, k inner) with incrementally tracked
  // row-major A, B and C indices so no address multipliers are needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt  <= '0;
      j_cnt  <= '0;
      k_cnt  <= '0;
      a_idx  <= '0;
      b_idx  <= '0;
      c_idx  <= '0;
      conj_q <= 1'b0;
    end else if (start_ok) begin
      i_cnt  <= '0;
      j_cnt  <= '0;
      k_cnt  <= '0;
      a_idx  <= '0;
      b_idx  <= '0;
      c_idx  <= '0;
      conj_q <= bus.conj_b;
    end else if (issue) begin
      if (k_cnt == K_LAST) begin
        k_cnt <= '0;
        c_idx <= c_idx + C_AW'(1);
        if (j_cnt == J_LAST) begin
          j_cnt <= '0;
          i_cnt <= i_cnt + I_W'(1);
          a_idx <= a_idx + A_AW'(1);
          b_idx <= '0;
        end else begin
          j_cnt <= j_cnt + J_W'(1);
          a_idx <= a_idx - A_AW'(K - 1);
          b_idx <= B_AW'(j_cnt) + B_AW'(1);
        end
      end else begin
        k_cnt <= k_cnt + K_W'(1);
        a_idx <= a_idx + A_AW'(1);
        b_idx <= b_idx + B_AW'(N);
      end
    end
  end

  // Pipeline valid chain; cleared by reset so an abort leaves no stray writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      s0_v <= issue;
      s1_v <= s0_v;
      s2_v <= s1_v;
      s3_v <= s2_v;
    end
  end

  // Datapath stages: issue, RAM read, four products, complex sum.
  always_ff @(posedge clk) begin
    s0_a     <= a_idx;
    s0_b     <= b_idx;
    s0_c     <= c_idx;
    s0_first <= (k_cnt == '0);
    s0_last  <= (k_cnt == K_LAST);

    a_re_q   <= a_re_mem[s0_a];
    a_im_q   <= a_im_mem[s0_a];
    b_re_q   <= b_re_mem[s0_b];
    b_im_q   <= b_im_mem[s0_b];
    s1_c     <= s0_c;
    s1_first <= s0_first;
    s1_last  <= s0_last;

    p_rr     <= PW'(a_re_q) * PW'(b_re_q);
    p_ii     <= PW'(a_im_q) * PW'(b_im_q);
    p_ri     <= PW'(a_re_q) * PW'(b_im_q);
    p_ir     <= PW'(a_im_q) * PW'(b_re_q);
    s2_c     <= s1_c;
    s2_first <= s1_first;
    s2_last  <= s1_last;

    if (conj_q) begin
      s3_re <= SW'(p_rr) + SW'(p_ii);
      s3_im <= SW'(p_ir) - SW'(p_ri);
    end else begin
      s3_re <= SW'(p_rr) - SW'(p_ii);
      s3_im <= SW'(p_ri) + SW'(p_ir);
    end
    s3_c     <= s2_c;
    s3_first <= s2_first;
    s3_last  <= s2_last;
  end

  // Accumulator update (load on k=0) and conversion of the running sum.
  always_comb begin
    acc_re_n = s3_first ? ACC_W'(s3_re) : (acc_re + ACC_W'(s3_re));
    acc_im_n = s3_first ? ACC_W'(s3_im) : (acc_im + ACC_W'(s3_im));
    conv_re  = to_q16(acc_re_n);
    conv_im  = to_q16(acc_im_n);
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (s3_v) begin
      acc_re <= acc_re_n;
      acc_im <= acc_im_n;
    end
  end

  // C buffer write of a finished element, re and im on the same edge.
  always_ff @(posedge clk) begin
    if (s3_v && s3_last) begin
      c_re_mem[s3_c] <= conv_re[DW-1:0];
      c_im_mem[s3_c] <= conv_im[DW-1:0];
    end
  end

  // Sticky saturation flag, cleared when a new run is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (start_ok) begin
      sat_q <= 1'b0;
    end else if (s3_v && s3_last && (conv_re[DW] || conv_im[DW])) begin
      sat_q <= 1'b1;
    end
  end

  // Registered C read port; a same-edge write is seen on the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_re_q <= '0;
      rd_im_q <= '0;
    end else begin
      rd_re_q <= c_re_mem[bus.rd_addr];
      rd_im_q <= c_im_mem[bus.rd_addr];
    end
  end
endmodule

// File: tb/tb_cmatmul_engine.sv
// Testbench for cmatmul_engine: table of uniform-matrix vectors with
// hand-computed Q16.16 results, plus directed sequences for addressing,
// abort, protocol corner cases and saturation on a K=128 instance.
module tb_cmatmul_engine;
  localparam int M     = 3;
  localparam int K     = 3;
  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int K2    = 128;
  localparam int A_AW  = $clog2(M * K);
  localparam int B_AW  = $clog2(K * N);
  localparam int C_AW  = $clog2(M * N);
  localparam int A2_AW = $clog2(M * K2);
  localparam int B2_AW = $clog2(K2 * N);

  typedef struct {
    string       name;
    bit          a_ident;
    logic [31:0] a_re;
    logic [31:0] a_im;
    logic [31:0] b_re;
    logic [31:0] b_im;
    bit          conj;
    logic [31:0] exp_re;
    logic [31:0] exp_im;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   edges;
  int   seen;
  vec_t vecs [7];

  always #5 clk = ~clk;

  cmatmul_engine_if #(.M(M), .K(K),  .N(N), .DW(DW)) bus  ();
  cmatmul_engine_if #(.M(M), .K(K2), .N(N), .DW(DW)) bus2 ();

  cmatmul_engine #(.M(M), .K(K),  .N(N), .DW(DW)) dut  (.clk(clk), .rst(rst), .bus(bus));
  cmatmul_engine #(.M(M), .K(K2), .N(N), .DW(DW)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic writeOperands(input int idx, input bit wa, input logic [31:0] are, input logic [31:0] aim,
                               input bit wb, input logic [31:0] bre, input logic [31:0] bim);
    @(negedge clk);
    bus.wr_a_en   = wa;
    bus.wr_a_addr = A_AW'(idx);
    bus.wr_a_re   = are;
    bus.wr_a_im   = aim;
    bus.wr_b_en   = wb;
    bus.wr_b_addr = B_AW'(idx);
    bus.wr_b_re   = bre;
    bus.wr_b_im   = bim;
    @(posedge clk);
    #1;
    bus.wr_a_en = 1'b0;
    bus.wr_b_en = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int e = 0; e < M * K; e++) begin
      logic [31:0] are;
      logic [31:0] aim;
      if (!v.a_ident || (e / K) == (e % K)) begin
        are = v.a_re;
        aim = v.a_im;
      end else begin
        are = 32'h0;
        aim = 32'h0;
      end
      writeOperands(e, 1'b1, are, aim, 1'b1, v.b_re, v.b_im);
    end
    bus.conj_b = v.conj;
  endtask

  task automatic runEngine(input string tag, output int n_edges);
    n_edges = -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n_edges = c;
        break;
      end
    end
    checkOutput({tag, "_done_edge"}, 32'(n_edges), 32'd32);
    checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  task automatic checkAllC(input string tag, input logic [31:0] er, input logic [31:0] ei);
    for (int e = 0; e < M * N; e++) begin
      @(negedge clk);
      bus.rd_addr = C_AW'(e);
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s_c%0d_re", tag, e), bus.rd_re, er);
      checkOutput($sformatf("%s_c%0d_im", tag, e), bus.rd_im, ei);
    end
  endtask

  initial begin
    bus.wr_a_en = 0; bus.wr_a_addr = '0; bus.wr_a_re = '0; bus.wr_a_im = '0;
    bus.wr_b_en = 0; bus.wr_b_addr = '0; bus.wr_b_re = '0; bus.wr_b_im = '0;
    bus.conj_b = 0; bus.start = 0; bus.rd_addr = '0;
    bus2.wr_a_en = 0; bus2.wr_a_addr = '0; bus2.wr_a_re = '0; bus2.wr_a_im = '0;
    bus2.wr_b_en = 0; bus2.wr_b_addr = '0; bus2.wr_b_re = '0; bus2.wr_b_im = '0;
    bus2.conj_b = 0; bus2.start = 0; bus2.rd_addr = '0;
    rst = 1'b1;

    vecs[0] = '{"ident",    1'b1, 32'h0800_0000, 32'h0,         32'h0400_0000, 32'h0200_0000, 1'b0, 32'h0000_8000, 32'h0000_4000};
    vecs[1] = '{"ja_b1",    1'b0, 32'h0,         32'h0800_0000, 32'h0800_0000, 32'h0,         1'b0, 32'h0000_0000, 32'h0003_0000};
    vecs[2] = '{"ja_jb_cj", 1'b0, 32'h0,         32'h0800_0000, 32'h0,         32'h0800_0000, 1'b1, 32'h0003_0000, 32'h0000_0000};
    vecs[3] = '{"neg",      1'b0, 32'hF800_0000, 32'h0,         32'h0200_0000, 32'hFC00_0000, 1'b0, 32'hFFFF_4000, 32'h0001_8000};
    vecs[4] = '{"floor",    1'b0, 32'h0800_0000, 32'h0,         32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{"mix_cj",   1'b0, 32'h0800_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 1'b1, 32'h0002_4000, 32'hFFFF_4000};
    vecs[6] = '{"mix",      1'b0, 32'h0800_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 1'b0, 32'h0000_C000, 32'h0002_4000};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy",  32'(bus.busy),  32'd0);
    checkOutput("rst_done",  32'(bus.done),  32'd0);
    checkOutput("rst_sat",   32'(bus.sat),   32'd0);
    checkOutput("rst_rd_re", bus.rd_re,      32'h0);
    checkOutput("rst_rd_im", bus.rd_im,      32'h0);
    checkOutput("rst_busy2", 32'(bus2.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v]);
      runEngine(vecs[v].name, edges);
      checkOutput({vecs[v].name, "_sat"}, 32'(bus.sat), 32'd0);
      checkAllC(vecs[v].name, vecs[v].exp_re, vecs[v].exp_im);
    end

    // Distinct B elements through an identity A: exercises row-major
    // addressing and a back-to-back read sweep.
    for (int e = 0; e < M * K; e++) begin
      writeOperands(e, 1'b1, ((e / K) == (e % K)) ? 32'h0800_0000 : 32'h0, 32'h0,
                    1'b1, 32'(e * 524288), 32'(-(e * 524288)));
    end
    bus.conj_b = 1'b0;
    runEngine("sweep", edges);
    for (int e = 0; e < M * N; e++) begin
      @(negedge clk);
      bus.rd_addr = C_AW'(e);
      @(posedge clk);
      #1;
      checkOutput($sformatf("sweep_c%0d_re", e), bus.rd_re, 32'(e * 256));
      checkOutput($sformatf("sweep_c%0d_im", e), bus.rd_im, 32'(-(e * 256)));
    end

    // Abort ten cycles into a run, then reload and rerun.
    applyStimulus(vecs[0]);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    checkOutput("abort_no_done", 32'(seen), 32'd0);
    applyStimulus(vecs[0]);
    runEngine("restart", edges);
    @(negedge clk);
    bus.rd_addr = C_AW'(4);
    @(posedge clk);
    #1;
    checkOutput("read_addr4", bus.rd_re, 32'h0000_8000);
    checkAllC("restart", 32'h0000_8000, 32'h0000_4000);

    // start pulsed mid-run and an A write while busy must both be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    edges = -1;
    for (int c = 1; c <= 200; c++) begin
      bus.start     = (c == 10);
      bus.wr_a_en   = (c == 5);
      bus.wr_a_addr = '0;
      bus.wr_a_re   = 32'h0;
      bus.wr_a_im   = 32'h0;
      @(posedge clk);
      #1;
      if (bus.done) begin
        edges = c;
        break;
      end
    end
    bus.start   = 1'b0;
    bus.wr_a_en = 1'b0;
    checkOutput("proto_done_edge", 32'(edges), 32'd32);
    @(posedge clk);
    #1;
    checkOutput("proto_done_one_cycle", 32'(bus.done), 32'd0);
    runEngine("proto_rerun", edges);
    checkAllC("proto_rerun", 32'h0000_8000, 32'h0000_4000);

    // start together with rst: reset wins and the engine stays idle.
    @(negedge clk);
    bus.start = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) seen++;
    end
    checkOutput("start_rst_idle", 32'(seen), 32'd0);

    // K=128 instance: every term is (-16)*(-16), the sum clamps positive.
    for (int e = 0; e < M * K2; e++) begin
      @(negedge clk);
      bus2.wr_a_en   = 1'b1;
      bus2.wr_a_addr = A2_AW'(e);
      bus2.wr_a_re   = 32'h8000_0000;
      bus2.wr_a_im   = 32'h0;
      bus2.wr_b_en   = 1'b1;
      bus2.wr_b_addr = B2_AW'(e);
      bus2.wr_b_re   = 32'h8000_0000;
      bus2.wr_b_im   = 32'h0;
    end
    @(negedge clk);
    bus2.wr_a_en = 1'b0;
    bus2.wr_b_en = 1'b0;
    bus2.conj_b  = 1'b0;
    bus2.start   = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    edges = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk);
      #1;
      if (bus2.done) begin
        edges = c;
        break;
      end
    end
    checkOutput("k128_done_edge", 32'(edges), 32'd1157);
    checkOutput("k128_sat", 32'(bus2.sat), 32'd1);
    @(posedge clk);
    #1;
    for (int e = 0; e < M * N; e++) begin
      @(negedge clk);
      bus2.rd_addr = C_AW'(e);
      @(posedge clk);
      #1;
      checkOutput($sformatf("k128_c%0d_re", e), bus2.rd_re, 32'h7FFF_FFFF);
      checkOutput($sformatf("k128_c%0d_im", e), bus2.rd_im, 32'h0);
    end
    @(negedge clk);
    bus2.start = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    checkOutput("k128_sat_cleared", 32'(bus2.sat), 32'd0);
    edges = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk);
      #1;
      if (bus2.done) begin
        edges = c;
        break;
      end
    end
    checkOutput("k128_rerun_done_edge", 32'(edges), 32'd1157);
    checkOutput("k128_rerun_sat", 32'(bus2.sat), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
